cpu_control_unit: RTL

//  Fetch/decode/execute sequencer of the 4-bit CPU; sits directly upstream of the ALU.

---
 rtl/cpu_control_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer of the 4-bit CPU: PC, IR, zero flag and call stack.
// Optional single-step mode is enabled by defining CTRL_SINGLE_STEP_EN.
module cpu_control_unit #(
    parameter int PC_W        = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic            clk,
    input  logic            rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] instr_addr,
    input  logic [11:0]     instr_data,
    output logic [3:0]      alu_op,
    output logic [3:0]      alu_imm,
    input  logic            zero,
    output logic [3:0]      rf_rd_a_sel,
    output logic [3:0]      rf_rd_b_sel,
    output logic [3:0]      rf_wr_sel,
    output logic            rf_we,
    output logic [3:0]      mem_addr,
    output logic            mem_re,
    output logic            mem_we,
    output logic            halted,
    output logic            stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        s_fetch,
        s_decode,
        s_exec,
        s_halt
`ifdef CTRL_SINGLE_STEP_EN
        , s_step_wait
`endif
    } state_t;

    state_t            state, state_n;
    logic [PC_W-1:0]   pc, pc_n, pc_inc, target;
    logic [SP_W-1:0]   sp, sp_n, sp_dec;
    logic [11:0]       ir;
    logic              zero_q, zero_ld, err_set, push;
    logic [PC_W-1:0]   stack [STACK_DEPTH];

    logic [3:0] opc, fa, fb;
    logic       exec_live;

    assign opc    = ir[11:8];
    assign fa     = ir[7:4];
    assign fb     = ir[3:0];
    assign pc_inc = pc + PC_W'(1);
    assign sp_dec = sp - SP_W'(1);
    assign target = PC_W'(fb);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n = state;
        pc_n    = pc;
        sp_n    = sp;
        push    = 1'b0;
        zero_ld = 1'b0;
        err_set = 1'b0;
        case (state)
            s_fetch:  state_n = s_decode;
            s_decode: state_n = s_exec;
            s_exec: begin
`ifdef CTRL_SINGLE_STEP_EN
                state_n = s_step_wait;
`else
                state_n = s_fetch;
`endif
                pc_n = pc_inc;
                case (opc)
                    4'b1100: pc_n = target;
                    4'b1101: if (zero_q) pc_n = target;
                    4'b1110: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            pc_n    = pc;
                            err_set = 1'b1;
                            state_n = s_halt;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + SP_W'(1);
                            pc_n = target;
                        end
                    end
                    4'b1111: begin
                        if (fb == 4'hF) begin
                            pc_n    = pc;
                            state_n = s_halt;
                        end else if (sp == '0) begin
                            pc_n    = pc;
                            err_set = 1'b1;
                            state_n = s_halt;
                        end else begin
                            sp_n = sp_dec;
                            pc_n = stack[IDX_W'(sp_dec)];
                        end
                    end
                    default: zero_ld = (opc <= 4'b0111);
                endcase
            end
            s_halt: state_n = s_halt;
`ifdef CTRL_SINGLE_STEP_EN
            s_step_wait: if (step) state_n = s_fetch;
`endif
            default: state_n = s_fetch;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state     <= s_fetch;
            pc        <= PC_W'(RESET_PC);
            sp        <= '0;
            ir        <= '0;
            zero_q    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            sp    <= sp_n;
            if (state == s_decode) ir <= instr_data;
            if (zero_ld) zero_q <= zero;
            if (err_set) stack_err <= 1'b1;
        end
    end

    // NOTE: stack entries have no reset; an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push) stack[IDX_W'(sp)] <= pc_inc;
    end

    // Strobes are masked by rst so an instruction aborted in EXEC never writes.
    assign exec_live   = (state == s_exec) && !rst;
    assign instr_addr  = pc;
    assign alu_op      = (state == s_exec) ? opc : 4'b0000;
    assign alu_imm     = fb;
    assign rf_rd_a_sel = fa;
    assign rf_rd_b_sel = fb;
    assign rf_wr_sel   = fa;
    assign rf_we       = exec_live && (opc <= 4'b1010);
    assign mem_re      = exec_live && (opc == 4'b1010);
    assign mem_we      = exec_live && (opc == 4'b1011);
    assign mem_addr    = (opc == 4'b1011) ? fa : fb;
    assign halted      = (state == s_halt);

endmodule
